seq_divider: RTL and testbench

Sequential restoring shift-subtract divider, the inverse of the shift-add multiplier (`FSA`). It takes a 2·WIDTH-bit dividend and a WIDTH-bit divisor and produces a 2·WIDTH-bit quotient and a WIDTH-bit remainder, one quotient bit per clock. It sits alongside the multiplier in the arithmetic datapath. A product from the multiplier can be divided by either of its operands to recover the other.

---
 rtl/seq_divider_pkg.sv | 19 +
 rtl/seq_divider_if.sv | 27 ++
 rtl/seq_divider_div_step.sv | 24 ++
 rtl/seq_divider.sv | 129 ++++++++++++
 tb/tb_seq_divider.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: FSM encoding, default width
// (common with the shift-add multiplier) and the iteration counter width.
package seq_divider_pkg;

    localparam int unsigned DEF_WIDTH = 12;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    // Counter must index 2*w iterations.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(2 * w);
    endfunction

    localparam int unsigned DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between a divider client (master) and seq_divider (slave).
interface seq_divider_if
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) ();

    logic                 start;
    logic [2*WIDTH-1:0]   Dividend;
    logic [WIDTH-1:0]     Divisor;
    logic                 busy;
    logic                 done;
    logic                 dz;
    logic [2*WIDTH-1:0]   Quotient;
    logic [WIDTH-1:0]     Remainder;

    modport master (
        output start, Dividend, Divisor,
        input  busy, done, dz, Quotient, Remainder
    );

    modport slave (
        input  start, Dividend, Divisor,
        output busy, done, dz, Quotient, Remainder
    );

endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
    parameter int unsigned WIDTH = 12
) (
    input  logic [WIDTH-1:0] p,
    input  logic             din,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] p_next_c,
    output logic             q_bit_c
);

    logic [WIDTH:0] p_shift;
    logic           fits;

    // The result is always below the divisor, so it fits back into WIDTH bits.
    always_comb begin
        p_shift  = {p, din};
        fits     = (p_shift >= {1'b0, divisor});
        q_bit_c  = fits;
        p_next_c = fits ? WIDTH'(p_shift - {1'b0, divisor}) : p_shift[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per clock, with a one-cycle divide-by-zero path.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);

    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned CW = cnt_width(WIDTH);

    state_t            state_q, state_d;
    logic [DW-1:0]     sr_q, sr_d;
    logic [WIDTH-1:0]  dvs_q, dvs_d;
    logic [WIDTH-1:0]  p_q, p_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              dzp_q, dzp_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              dz_q, dz_d;
    logic [DW-1:0]     quot_q, quot_d;
    logic [WIDTH-1:0]  rem_q, rem_d;

    logic [WIDTH-1:0]  step_p;
    logic              step_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .p        (p_q),
        .din      (sr_q[DW-1]),
        .divisor  (dvs_q),
        .p_next_c (step_p),
        .q_bit_c  (step_q)
    );

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.dz        = dz_q;
    assign bus.Quotient  = quot_q;
    assign bus.Remainder = rem_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            dvs_q   <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            dzp_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            dvs_q   <= dvs_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            dzp_q   <= dzp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        dvs_d   = dvs_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        dzp_d   = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        quot_d  = quot_q;
        rem_d   = rem_q;

        case (state_q)
            IDLE: begin
                if (dzp_q) begin
                    // Divide-by-zero result lands one cycle after acceptance.
                    quot_d = '1;
                    rem_d  = sr_q[WIDTH-1:0];
                    dz_d   = 1'b1;
                    done_d = 1'b1;
                end else if (bus.start) begin
                    sr_d  = bus.Dividend;
                    dvs_d = bus.Divisor;
                    p_d   = '0;
                    cnt_d = '0;
                    if (bus.Divisor == '0) begin
                        dzp_d = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                // Quotient bits fill the LSBs vacated by the dividend shift.
                p_d   = step_p;
                sr_d  = {sr_q[DW-2:0], step_q};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DW - 1)) begin
                    quot_d  = {sr_q[DW-2:0], step_q};
                    rem_d   = step_p;
                    dz_d    = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus random operands
// compared against plain integer division.
module tb_seq_divider;

    localparam int unsigned W  = 12;
    localparam int unsigned DW = 2 * W;
    localparam int          LAT = 2 * W;

    logic clk;
    logic rst;

    int unsigned passed;
    int unsigned total;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Reference: integer division, or the defined divide-by-zero result.
    task automatic ref_div(input logic [DW-1:0] a, input logic [W-1:0] b,
                           output logic [DW-1:0] q, output logic [W-1:0] r);
        if (b == 0) begin
            q = {DW{1'b1}};
            r = a[W-1:0];
        end else begin
            q = DW'(a / DW'(b));
            r = W'(a % DW'(b));
        end
    endtask

    // Issue one operation and check latency, busy behaviour and results.
    task automatic do_op(input logic [DW-1:0] a, input logic [W-1:0] b, input string tag);
        logic [DW-1:0] eq;
        logic [W-1:0]  er;
        int            lat;
        logic          busy_ok;
        ref_div(a, b, eq, er);
        bus.start    = 1'b1;
        bus.Dividend = a;
        bus.Divisor  = b;
        tick();
        bus.start = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (b != 0 && lat >= 1 && bus.busy !== 1'b1) busy_ok = 1'b0;
            if (b == 0 && bus.busy !== 1'b0) busy_ok = 1'b0;
            tick();
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), (b == 0) ? 32'd1 : 32'(LAT));
        chk({tag, " busy"},    32'(busy_ok), 32'd1);
        chk({tag, " busy_end"}, 32'(bus.busy), 32'd0);
        chk({tag, " quotient"}, 32'(bus.Quotient), 32'(eq));
        chk({tag, " remainder"}, 32'(bus.Remainder), 32'(er));
        chk({tag, " dz"}, 32'(bus.dz), (b == 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        logic [DW-1:0] ra;
        logic [W-1:0]  rb;
        int            lat;
        int            mode;

        passed       = 0;
        total        = 0;
        rst          = 1'b0;
        bus.start    = 1'b0;
        bus.Dividend = '0;
        bus.Divisor  = '0;

        repeat (2) @(negedge clk);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst dz",   32'(bus.dz),   32'd0);
        chk("rst quot", 32'(bus.Quotient),  32'd0);
        chk("rst rem",  32'(bus.Remainder), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        do_op(24'd1000, 12'd7, "d1000_7");
        tick();
        chk("done_fall", 32'(bus.done), 32'd0);
        chk("hold_quot", 32'(bus.Quotient), 32'd142);
        chk("hold_rem",  32'(bus.Remainder), 32'd6);

        do_op(24'd16777215, 12'd4095, "dmax");
        do_op(24'd12000000, 12'd4000, "fsa_trip");
        do_op(24'd5, 12'd9, "d5_9");
        do_op(24'd500, 12'd0, "dz500");
        tick();
        chk("dz done_fall", 32'(bus.done), 32'd0);
        chk("dz hold", 32'(bus.dz), 32'd1);

        // Start pulse during an operation must be ignored.
        bus.start    = 1'b1;
        bus.Dividend = 24'd1000;
        bus.Divisor  = 12'd7;
        tick();
        bus.start = 1'b0;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (lat == 9) begin
                bus.start    = 1'b1;
                bus.Dividend = 24'd77777;
                bus.Divisor  = 12'd3;
            end
            tick();
            bus.start = 1'b0;
            lat++;
        end
        chk("ignore latency", 32'(lat), 32'(LAT));
        chk("ignore quot", 32'(bus.Quotient), 32'd142);
        chk("ignore rem",  32'(bus.Remainder), 32'd6);
        chk("ignore dz",   32'(bus.dz), 32'd0);
        do_op(24'd654321, 12'd123, "back2back");

        // Asynchronous reset mid-operation aborts with no done.
        bus.start    = 1'b1;
        bus.Dividend = 24'd1000;
        bus.Divisor  = 12'd7;
        tick();
        bus.start = 1'b0;
        repeat (11) tick();
        chk("pre_rst busy", 32'(bus.busy), 32'd1);
        @(posedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst busy", 32'(bus.busy), 32'd0);
        chk("mid_rst quot", 32'(bus.Quotient), 32'd0);
        chk("mid_rst rem",  32'(bus.Remainder), 32'd0);
        chk("mid_rst done", 32'(bus.done), 32'd0);
        repeat (3) tick();
        chk("rst_hold done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) tick();
        chk("post_rst done", 32'(bus.done), 32'd0);
        do_op(24'd100, 12'd10, "d100_10");

        // Random operands, including small and zero divisors.
        for (int i = 0; i < 25; i++) begin
            ra   = DW'($urandom);
            mode = int'($urandom_range(0, 9));
            if (mode == 0)      rb = '0;
            else if (mode < 4)  rb = W'($urandom_range(1, 15));
            else                rb = W'($urandom);
            if (i % 3 == 0) repeat (int'($urandom_range(1, 3))) tick();
            do_op(ra, rb, $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
